// File: rtl/blackjack_pkg.sv
// Shared definitions for the blackjack datapath: score width, game limits,
// controller state encoding and the handshake target selector.
package blackjack_pkg;

    // Score width shared with the scoring unit
    localparam int SCORE_W = 6;
    // Width of the per-hand card counters
    localparam int CNT_W = 3;

    localparam logic [SCORE_W-1:0] BLACKJACK    = SCORE_W'(21);
    localparam logic [SCORE_W-1:0] DEALER_STAND = SCORE_W'(17);
    localparam logic [CNT_W-1:0]   MAX_CARDS    = CNT_W'(5);
    localparam int                 HS_TIMEOUT   = 64;

    // Game controller states
    typedef enum logic [3:0] {
        OCIOSO,
        DEAL_J1,
        DEAL_D1,
        DEAL_J2,
        DEAL_D2,
        VEZ_JOG,
        HIT_J,
        VEZ_DEALER,
        HIT_D,
        COMPARA,
        FIM,
        ERRO
    } estado_t;

    // Which hand the next scored card belongs to
    typedef enum logic {
        ALVO_JOG,
        ALVO_DEALER
    } alvo_t;

    // Handshake engine phases
    typedef enum logic [1:0] {
        HS_IDLE,
        HS_REQ,
        HS_REL,
        HS_SETTLE
    } hs_estado_t;

    // Card counter increment that holds at the hand limit
    function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] n);
        return (n < MAX_CARDS) ? n + CNT_W'(1) : n;
    endfunction

endpackage

// File: rtl/hs_iniciador.sv
// Initiator side of the 4-phase card-scoring handshake. One transaction per
// go pulse: raise the request for the chosen hand, wait for cartaok, drop the
// request, wait for cartaok to fall, settle one cycle, then pulse feito.
// Any REQ or REL phase lasting TIMEOUT cycles aborts with a timeout pulse.
module hs_iniciador
    import blackjack_pkg::*;
#(
    parameter int TIMEOUT = HS_TIMEOUT
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  go,
    input  alvo_t alvo,
    input  logic  cartaok,
    output logic  pjogador,
    output logic  pdealer,
    output logic  feito,
    output logic  timeout
);

    localparam int TO_W = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    hs_estado_t      hs, hs_next;
    logic [TO_W-1:0] cnt, cnt_next;
    logic            pj_next, pd_next, feito_next, to_next;

    // Phase register and registered request/status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs       <= HS_IDLE;
            cnt      <= '0;
            pjogador <= 1'b0;
            pdealer  <= 1'b0;
            feito    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            hs       <= hs_next;
            cnt      <= cnt_next;
            pjogador <= pj_next;
            pdealer  <= pd_next;
            feito    <= feito_next;
            timeout  <= to_next;
        end
    end

    // Phase sequencing; the counter restarts on every phase entry
    always_comb begin
        hs_next    = hs;
        cnt_next   = cnt + TO_W'(1);
        pj_next    = pjogador;
        pd_next    = pdealer;
        feito_next = 1'b0;
        to_next    = 1'b0;
        case (hs)
            HS_IDLE: begin
                cnt_next = '0;
                pj_next  = 1'b0;
                pd_next  = 1'b0;
                if (go) begin
                    hs_next = HS_REQ;
                    pj_next = (alvo == ALVO_JOG);
                    pd_next = (alvo == ALVO_DEALER);
                end
            end
            HS_REQ: begin
                if (cartaok) begin
                    hs_next  = HS_REL;
                    cnt_next = '0;
                    pj_next  = 1'b0;
                    pd_next  = 1'b0;
                end else if (cnt == TO_LAST) begin
                    hs_next  = HS_IDLE;
                    cnt_next = '0;
                    pj_next  = 1'b0;
                    pd_next  = 1'b0;
                    to_next  = 1'b1;
                end
            end
            HS_REL: begin
                if (!cartaok) begin
                    hs_next  = HS_SETTLE;
                    cnt_next = '0;
                end else if (cnt == TO_LAST) begin
                    hs_next  = HS_IDLE;
                    cnt_next = '0;
                    to_next  = 1'b1;
                end
            end
            HS_SETTLE: begin
                hs_next    = HS_IDLE;
                cnt_next   = '0;
                feito_next = 1'b1;
            end
            default: begin
                hs_next  = HS_IDLE;
                cnt_next = '0;
                pj_next  = 1'b0;
                pd_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/controle_jogo.sv
// Blackjack game controller: deals two cards to each hand, runs the player
// hit/stay turn and the dealer draw rule through the handshake engine, then
// compares the accumulated scores and latches one result flag.
module controle_jogo
    import blackjack_pkg::*;
#(
    parameter int TIMEOUT = HS_TIMEOUT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               hit,
    input  logic               stay,
    input  logic               cartaok,
    input  logic [SCORE_W-1:0] pts_jogador,
    input  logic [SCORE_W-1:0] pts_dealer,
    output logic               pjogador,
    output logic               pdealer,
    output logic               nova_rodada,
    output logic [CNT_W-1:0]   n_jog,
    output logic [CNT_W-1:0]   n_dealer,
    output logic               busy,
    output logic               vitoria,
    output logic               derrota,
    output logic               empate,
    output logic               erro
);

    estado_t          estado, estado_next;
    logic [CNT_W-1:0] n_jog_next, n_dealer_next;
    logic             nova_next, busy_next;
    logic             vit_next, der_next, emp_next, erro_next;
    logic             hs_go, hs_feito, hs_timeout;
    alvo_t            hs_alvo;
    logic             jog_estourou, dealer_estourou;

    assign jog_estourou    = (pts_jogador > BLACKJACK);
    assign dealer_estourou = (pts_dealer > BLACKJACK);

    hs_iniciador #(
        .TIMEOUT(TIMEOUT)
    ) u_hs (
        .clock   (clock),
        .reset   (reset),
        .go      (hs_go),
        .alvo    (hs_alvo),
        .cartaok (cartaok),
        .pjogador(pjogador),
        .pdealer (pdealer),
        .feito   (hs_feito),
        .timeout (hs_timeout)
    );

    // Game state register and registered status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado      <= OCIOSO;
            n_jog       <= '0;
            n_dealer    <= '0;
            nova_rodada <= 1'b0;
            busy        <= 1'b0;
            vitoria     <= 1'b0;
            derrota     <= 1'b0;
            empate      <= 1'b0;
            erro        <= 1'b0;
        end else begin
            estado      <= estado_next;
            n_jog       <= n_jog_next;
            n_dealer    <= n_dealer_next;
            nova_rodada <= nova_next;
            busy        <= busy_next;
            vitoria     <= vit_next;
            derrota     <= der_next;
            empate      <= emp_next;
            erro        <= erro_next;
        end
    end

    // Game sequencing; a handshake is launched on the transition into the
    // state that waits for it, so engine and FSM move on the same edge
    always_comb begin
        estado_next   = estado;
        n_jog_next    = n_jog;
        n_dealer_next = n_dealer;
        nova_next     = 1'b0;
        busy_next     = busy;
        vit_next      = vitoria;
        der_next      = derrota;
        emp_next      = empate;
        erro_next     = erro;
        hs_go         = 1'b0;
        hs_alvo       = ALVO_JOG;
        case (estado)
            OCIOSO, FIM, ERRO: begin
                if (start) begin
                    estado_next   = DEAL_J1;
                    nova_next     = 1'b1;
                    busy_next     = 1'b1;
                    n_jog_next    = '0;
                    n_dealer_next = '0;
                    vit_next      = 1'b0;
                    der_next      = 1'b0;
                    emp_next      = 1'b0;
                    erro_next     = 1'b0;
                    hs_go         = 1'b1;
                    hs_alvo       = ALVO_JOG;
                end
            end
            DEAL_J1: begin
                if (hs_timeout) begin
                    estado_next = ERRO;
                    erro_next   = 1'b1;
                    busy_next   = 1'b0;
                end else if (hs_feito) begin
                    n_jog_next  = inc_sat(n_jog);
                    estado_next = DEAL_D1;
                    hs_go       = 1'b1;
                    hs_alvo     = ALVO_DEALER;
                end
            end
            DEAL_D1: begin
                if (hs_timeout) begin
                    estado_next = ERRO;
                    erro_next   = 1'b1;
                    busy_next   = 1'b0;
                end else if (hs_feito) begin
                    n_dealer_next = inc_sat(n_dealer);
                    estado_next   = DEAL_J2;
                    hs_go         = 1'b1;
                    hs_alvo       = ALVO_JOG;
                end
            end
            DEAL_J2: begin
                if (hs_timeout) begin
                    estado_next = ERRO;
                    erro_next   = 1'b1;
                    busy_next   = 1'b0;
                end else if (hs_feito) begin
                    n_jog_next  = inc_sat(n_jog);
                    estado_next = DEAL_D2;
                    hs_go       = 1'b1;
                    hs_alvo     = ALVO_DEALER;
                end
            end
            DEAL_D2: begin
                if (hs_timeout) begin
                    estado_next = ERRO;
                    erro_next   = 1'b1;
                    busy_next   = 1'b0;
                end else if (hs_feito) begin
                    n_dealer_next = inc_sat(n_dealer);
                    // A natural blackjack skips the player's turn
                    estado_next   = (pts_jogador == BLACKJACK) ? VEZ_DEALER : VEZ_JOG;
                end
            end
            VEZ_JOG: begin
                if (jog_estourou) begin
                    estado_next = COMPARA;
                end else if (stay) begin
                    estado_next = VEZ_DEALER;
                end else if (hit) begin
                    if (n_jog < MAX_CARDS) begin
                        estado_next = HIT_J;
                        hs_go       = 1'b1;
                        hs_alvo     = ALVO_JOG;
                    end else begin
                        estado_next = VEZ_DEALER;
                    end
                end
            end
            HIT_J: begin
                if (hs_timeout) begin
                    estado_next = ERRO;
                    erro_next   = 1'b1;
                    busy_next   = 1'b0;
                end else if (hs_feito) begin
                    n_jog_next  = inc_sat(n_jog);
                    estado_next = VEZ_JOG;
                end
            end
            VEZ_DEALER: begin
                if (jog_estourou) begin
                    estado_next = COMPARA;
                end else if ((pts_dealer < DEALER_STAND) && (n_dealer < MAX_CARDS)) begin
                    estado_next = HIT_D;
                    hs_go       = 1'b1;
                    hs_alvo     = ALVO_DEALER;
                end else begin
                    estado_next = COMPARA;
                end
            end
            HIT_D: begin
                if (hs_timeout) begin
                    estado_next = ERRO;
                    erro_next   = 1'b1;
                    busy_next   = 1'b0;
                end else if (hs_feito) begin
                    n_dealer_next = inc_sat(n_dealer);
                    estado_next   = VEZ_DEALER;
                end
            end
            COMPARA: begin
                if (jog_estourou) begin
                    der_next = 1'b1;
                end else if (dealer_estourou) begin
                    vit_next = 1'b1;
                end else if (pts_jogador > pts_dealer) begin
                    vit_next = 1'b1;
                end else if (pts_jogador == pts_dealer) begin
                    emp_next = 1'b1;
                end else begin
                    der_next = 1'b1;
                end
                busy_next   = 1'b0;
                estado_next = FIM;
            end
            default: begin
                estado_next = OCIOSO;
                busy_next   = 1'b0;
            end
        endcase
    end

endmodule
